// File: rtl/counter_updown_mod.sv
// counter_updown_mod: programmable up/down modulo counter with runtime bounds,
// one-shot halt and cascade chaining (co of one stage drives ci of the next).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clr                 sync clear to start bound, leaves HALT
//   cfg_we, lo, hi      sync write of lower/upper bounds
//   load, din           sync load of q
//   en, ci, dir         count enable, cascade enable, 1=up / 0=down
//   oneshot             1=halt at terminal, 0=wrap to opposite bound
//   q                   registered count
//   tc, co              combinational terminal / carry-out
//   wrap                registered 1-cycle pulse on a wrap step
//   done                high while halted
//   cfg_err             sticky flag: bounds written with lo>hi
module counter_updown_mod #(
  parameter int unsigned      WIDTH  = 10,
  parameter logic [WIDTH-1:0] ST_DEF = '0,
  parameter logic [WIDTH-1:0] N_DEF  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             ci,
  input  logic             dir,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             wrap,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] lo_r, hi_r, lo_n, hi_n, q_n;
  logic             wrap_n, cfg_err_n, step;

  // Terminal compare uses >=/<= so an out-of-range loaded q still terminates.
  assign tc   = dir ? (q >= hi_r) : (q <= lo_r);
  assign step = en & ci & (state == RUN);
  assign co   = tc & step;
  assign done = (state == HALT);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      q       <= ST_DEF;
      lo_r    <= ST_DEF;
      hi_r    <= N_DEF;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      lo_r    <= lo_n;
      hi_r    <= hi_n;
      wrap    <= wrap_n;
      cfg_err <= cfg_err_n;
    end
  end

  // Next-state: clr > load > step for q/state; bound writes run in parallel.
  always_comb begin
    state_n   = state;
    q_n       = q;
    lo_n      = lo_r;
    hi_n      = hi_r;
    wrap_n    = 1'b0;
    cfg_err_n = cfg_err;

    if (clr) begin
      q_n       = dir ? lo_r : hi_r;
      state_n   = RUN;
      cfg_err_n = 1'b0;
    end else if (load) begin
      q_n     = din;
      state_n = RUN;
    end else if (step) begin
      if (dir) begin
        if (q < hi_r) begin
          q_n = q + WIDTH'(1);
        end else if (oneshot) begin
          q_n     = hi_r;
          state_n = HALT;
        end else begin
          q_n    = lo_r;
          wrap_n = 1'b1;
        end
      end else begin
        if (q > lo_r) begin
          q_n = q - WIDTH'(1);
        end else if (oneshot) begin
          q_n     = lo_r;
          state_n = HALT;
        end else begin
          q_n    = hi_r;
          wrap_n = 1'b1;
        end
      end
    end

    // Evaluated after clr so a bad write on the same edge is not lost.
    if (cfg_we) begin
      lo_n = lo;
      hi_n = hi;
      if (lo > hi) cfg_err_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: a reference model pushes the
// expected {q,wrap,done,cfg_err,tc,co} into a scoreboard per driven cycle and
// each test pops and compares after the clock edge.
`timescale 1ns/1ps
module tb_counter_updown_mod;

  typedef logic [14:0] vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr, cfg_we, load, en, ci, dir, oneshot;
  logic [9:0] lo, hi, din;
  logic [9:0] q;
  logic       tc, co, wrap, done, cfg_err;

  // Cascade pair of 4-bit stages.
  logic       c_en;
  logic [3:0] q0, q1;
  logic       tc0, co0, wrap0, done0, err0;
  logic       tc1, co1, wrap1, done1, err1;

  int total = 0;
  int bad   = 0;

  vec_t        sb[$];
  logic [16:0] csb[$];

  // Reference model state.
  logic [9:0] mq, mlo, mhi;
  logic       mhalt, mwrap, merr;

  always #5 clk = ~clk;

  counter_updown_mod u_dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .cfg_we(cfg_we), .lo(lo), .hi(hi),
    .load(load), .din(din), .en(en), .ci(ci), .dir(dir), .oneshot(oneshot),
    .q(q), .tc(tc), .co(co), .wrap(wrap), .done(done), .cfg_err(cfg_err)
  );

  counter_updown_mod #(.WIDTH(4)) u_c0 (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .cfg_we(1'b0), .lo(4'd0), .hi(4'd0),
    .load(1'b0), .din(4'd0), .en(c_en), .ci(1'b1), .dir(1'b1), .oneshot(1'b0),
    .q(q0), .tc(tc0), .co(co0), .wrap(wrap0), .done(done0), .cfg_err(err0)
  );

  counter_updown_mod #(.WIDTH(4)) u_c1 (
    .clk(clk), .reset_n(reset_n), .clr(1'b0), .cfg_we(1'b0), .lo(4'd0), .hi(4'd0),
    .load(1'b0), .din(4'd0), .en(c_en), .ci(co0), .dir(1'b1), .oneshot(1'b0),
    .q(q1), .tc(tc1), .co(co1), .wrap(wrap1), .done(done1), .cfg_err(err1)
  );

  function automatic vec_t obs_vec();
    return {q, wrap, done, cfg_err, tc, co};
  endfunction

  task automatic model_reset();
    mq = 10'd0; mlo = 10'd0; mhi = 10'd1023;
    mhalt = 1'b0; mwrap = 1'b0; merr = 1'b0;
  endtask

  // Advance the model by one edge with the inputs currently driven.
  task automatic model_push();
    logic [9:0] nq, nlo, nhi;
    logic       nh, nw, ne, mtc, mco;
    nq = mq; nlo = mlo; nhi = mhi; nh = mhalt; nw = 1'b0; ne = merr;
    if (clr) begin
      nq = dir ? mlo : mhi; nh = 1'b0; ne = 1'b0;
    end else if (load) begin
      nq = din; nh = 1'b0;
    end else if (en && ci && !mhalt) begin
      if (dir) begin
        if (mq < mhi)     nq = mq + 10'd1;
        else if (oneshot) begin nq = mhi; nh = 1'b1; end
        else              begin nq = mlo; nw = 1'b1; end
      end else begin
        if (mq > mlo)     nq = mq - 10'd1;
        else if (oneshot) begin nq = mlo; nh = 1'b1; end
        else              begin nq = mhi; nw = 1'b1; end
      end
    end
    if (cfg_we) begin
      nlo = lo; nhi = hi;
      if (lo > hi) ne = 1'b1;
    end
    mq = nq; mlo = nlo; mhi = nhi; mhalt = nh; mwrap = nw; merr = ne;
    mtc = dir ? (mq >= mhi) : (mq <= mlo);
    mco = mtc & en & ci & ~mhalt;
    sb.push_back({mq, mwrap, mhalt, merr, mtc, mco});
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; cfg_we = 0; load = 0; en = 0; ci = 1; dir = 1; oneshot = 0;
    lo = 0; hi = 0; din = 0;
  endtask

  task automatic test_reset();
    idle();
    c_en = 0;
    reset_n = 0;
    model_reset();
    #12;
    total++;
    if ({q, wrap, done, cfg_err} !== {10'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset got=%h want=%h", {q, wrap, done, cfg_err}, {10'd0, 3'b000});
    end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_range();
    vec_t e, o;
    en = 1; ci = 1; dir = 1;
    for (int i = 0; i < 1030; i++) begin
      tick();
      e = sb.pop_front(); o = obs_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL full_range[%0d] got=%h want=%h", i, o, e); end
      if (i == 1022) begin
        total++;
        if ({q, tc, co} !== {10'd1023, 2'b11}) begin
          bad++; $display("FAIL full_range_top got=%h want=%h", {q, tc, co}, {10'd1023, 2'b11});
        end
      end
      if (i == 1023) begin
        total++;
        if ({q, wrap} !== {10'd0, 1'b1}) begin
          bad++; $display("FAIL full_range_wrap got=%h want=%h", {q, wrap}, {10'd0, 1'b1});
        end
      end
    end
    en = 0;
  endtask

  task automatic test_down_bounds();
    vec_t e, o;
    idle();
    cfg_we = 1; lo = 10'd3; hi = 10'd9;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL down_cfg got=%h want=%h", o, e); end
    cfg_we = 0; clr = 1; dir = 0;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL down_clr got=%h want=%h", o, e); end
    clr = 0; en = 1;
    for (int i = 0; i < 8; i++) begin
      tick(); e = sb.pop_front(); o = obs_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL down_step[%0d] got=%h want=%h", i, o, e); end
      if (i == 6) begin
        total++;
        if ({q, wrap} !== {10'd9, 1'b1}) begin
          bad++; $display("FAIL down_wrap got=%h want=%h", {q, wrap}, {10'd9, 1'b1});
        end
      end
    end
    en = 0;
  endtask

  task automatic test_oneshot();
    vec_t e, o;
    idle();
    cfg_we = 1; lo = 10'd0; hi = 10'd5;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL os_cfg got=%h want=%h", o, e); end
    cfg_we = 0; clr = 1;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL os_clr got=%h want=%h", o, e); end
    clr = 0; oneshot = 1; en = 1;
    for (int i = 0; i < 8; i++) begin
      tick(); e = sb.pop_front(); o = obs_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL os_step[%0d] got=%h want=%h", i, o, e); end
    end
    total++;
    if ({q, done, co} !== {10'd5, 2'b10}) begin
      bad++; $display("FAIL os_halt got=%h want=%h", {q, done, co}, {10'd5, 2'b10});
    end
    load = 1; din = 10'd2;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL os_load got=%h want=%h", o, e); end
    load = 0;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL os_resume got=%h want=%h", o, e); end
    total++;
    if ({q, done} !== {10'd3, 1'b0}) begin
      bad++; $display("FAIL os_resume_q got=%h want=%h", {q, done}, {10'd3, 1'b0});
    end
    en = 0; oneshot = 0;
  endtask

  task automatic test_cascade();
    logic [16:0] e, o;
    logic [7:0]  n;
    c_en = 1;
    for (int k = 1; k <= 300; k++) begin
      n = 8'(k);
      csb.push_back({n, (n[3:0] == 4'd0), (n == 8'd0), (n[3:0] == 4'hf), (n[7:4] == 4'hf),
                     (n == 8'hff), 4'b0000});
      @(posedge clk);
      #1;
      e = csb.pop_front();
      o = {q1, q0, wrap0, wrap1, tc0, tc1, co1, done0, done1, err0, err1};
      total++;
      if (o !== e) begin bad++; $display("FAIL cascade[%0d] got=%h want=%h", k, o, e); end
    end
    c_en = 0;
  endtask

  task automatic test_load_range_err();
    vec_t e, o;
    idle();
    cfg_we = 1; lo = 10'd0; hi = 10'd9;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL lr_cfg got=%h want=%h", o, e); end
    cfg_we = 0; load = 1; din = 10'd12;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL lr_load got=%h want=%h", o, e); end
    load = 0; en = 1;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL lr_step got=%h want=%h", o, e); end
    total++;
    if ({q, wrap} !== {10'd0, 1'b1}) begin
      bad++; $display("FAIL lr_recover got=%h want=%h", {q, wrap}, {10'd0, 1'b1});
    end
    en = 0; cfg_we = 1; lo = 10'd8; hi = 10'd4;
    for (int i = 0; i < 3; i++) begin
      tick(); e = sb.pop_front(); o = obs_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL err_hold[%0d] got=%h want=%h", i, o, e); end
      cfg_we = 0;
    end
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", cfg_err); end
    clr = 1;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL err_clr got=%h want=%h", o, e); end
    total++;
    if ({cfg_err, q} !== {1'b0, 10'd8}) begin
      bad++; $display("FAIL err_clr_val got=%h want=%h", {cfg_err, q}, {1'b0, 10'd8});
    end
    clr = 0;
  endtask

  task automatic test_async_reset_priority();
    vec_t e, o;
    idle();
    cfg_we = 1; lo = 10'd8; hi = 10'd4;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL ar_cfg got=%h want=%h", o, e); end
    cfg_we = 0; load = 1; din = 10'd600;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL ar_load got=%h want=%h", o, e); end
    load = 0; dir = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); e = sb.pop_front(); o = obs_vec(); total++;
      if (o !== e) begin bad++; $display("FAIL ar_count[%0d] got=%h want=%h", i, o, e); end
    end
    en = 0;
    #2 reset_n = 0;
    model_reset();
    #1;
    total++;
    if ({q, wrap, done, cfg_err} !== {10'd0, 3'b000}) begin
      bad++; $display("FAIL ar_async got=%h want=%h", {q, wrap, done, cfg_err}, {10'd0, 3'b000});
    end
    total++;
    if (tc !== 1'b1) begin bad++; $display("FAIL ar_lo_default got=%b want=1", tc); end
    dir = 1;
    #1;
    total++;
    if (tc !== 1'b0) begin bad++; $display("FAIL ar_hi_default got=%b want=0", tc); end
    #1 reset_n = 1;
    @(posedge clk);
    #1;
    load = 1; din = 10'd7;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL pri_load got=%h want=%h", o, e); end
    clr = 1; din = 10'd20;
    tick(); e = sb.pop_front(); o = obs_vec(); total++;
    if (o !== e) begin bad++; $display("FAIL pri_clr got=%h want=%h", o, e); end
    total++;
    if (q !== 10'd0) begin bad++; $display("FAIL pri_clr_wins got=%0d want=0", q); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_range();
    test_down_bounds();
    test_oneshot();
    test_cascade();
    test_load_range_err();
    test_async_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
